muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer beside the single-cycle ALU; executes MULT/MULTU/DIV/DIVU

---
 rtl/muldiv_seq.sv | 126 ++++++++++++
 tb/tb_muldiv_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO access.
// Arithmetic ops take WIDTH+2 edges: latch, WIDTH shift steps, then sign fix and commit.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   raw_a;
  logic               is_div, neg_q, neg_r, dz;

  // The eight HI/LO codes are 01x0xx; bit 3 separates arithmetic from move ops.
  logic known, arith, sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign known = (funct[5:4] == 2'b01) && !funct[2];
  assign arith = known && funct[3];
  assign sgn   = !funct[0];
  assign a_neg = sgn && RA[WIDTH-1];
  assign b_neg = sgn && RB[WIDTH-1];
  assign a_mag = a_neg ? -RA : RA;
  assign b_mag = b_neg ? -RB : RB;

  assign busy  = (state != IDLE);
  assign stall = busy && start && known;

  // acc holds {upper product, multiplier} for MUL and {remainder, quotient} for DIV.
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign prod_fix = neg_q ? -acc : acc;
  assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && arith) begin
            state  <= RUN;
            cnt    <= '0;
            is_div <= funct[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= funct[1] && (RB == '0);
            raw_a  <= RA;
            if (funct[1]) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end else if (start && known && funct[0]) begin
            if (funct[1]) lo <= RA;
            else          hi <= RA;
          end
        end
        RUN: begin
          if (is_div) begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], !div_diff[WIDTH]};
            acc[2*WIDTH-1:WIDTH] <= div_diff[WIDTH] ? acc[2*WIDTH-2:WIDTH-1]
                                                    : div_diff[WIDTH-1:0];
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (dz) begin
            hi <= raw_a;
            lo <= {WIDTH{1'b1}};
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          done     <= 1'b1;
          div_zero <= is_div && dz;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed corner cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] RA = '0, RB = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero, stall;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001,
                         F_DIV = 6'b011010, F_DIVU = 6'b011011,
                         F_MFHI = 6'b010000, F_MTHI = 6'b010001,
                         F_MFLO = 6'b010010, F_MTLO = 6'b010011;

  int tests = 0;
  int fails = 0;
  logic [64:0] sb[$];

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .RA(RA), .RB(RB),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference: {div_zero, hi, lo} from 64-bit integer arithmetic.
  function automatic logic [64:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_;
    logic [63:0] p, q, r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    if ((f == F_DIV || f == F_DIVU) && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    case (f)
      F_MULT:  p = sa * sb_;
      F_MULTU: p = {32'd0, a} * {32'd0, b};
      F_DIV:   begin q = sa / sb_; r = sa % sb_; p = {r[31:0], q[31:0]}; end
      default: begin q = {32'd0, a} / {32'd0, b}; r = {32'd0, a} % {32'd0, b}; p = {r[31:0], q[31:0]}; end
    endcase
    return {1'b0, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [64:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: hi=%h lo=%h", hi, lo);
        end else begin
          e = sb.pop_front();
          if ({div_zero, hi, lo} !== e) begin
            fails++;
            $display("FAIL result: got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                     div_zero, hi, lo, e[64], e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      tests++;
      fails++;
      $display("FAIL timeout: busy=%b pending=%0d", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct = f; RA = a; RB = b;
    sb.push_back(model(f, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    launch(f, a, b);
    wait_idle();
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] d, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    @(negedge clk);
    start = 1'b1; funct = f; RA = d; RB = $urandom;
    #1 check("mt_stall_idle", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("mt_hilo", {hi, lo}, {hi_exp, lo_exp});
    check("mt_busy_done", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] h0, l0, a, b;
    logic [5:0] f;
    logic [5:0] ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

    #12;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MULT 7 * -3 with exact busy window
    launch(F_MULT, 32'd7, 32'hFFFF_FFFD);
    n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("mult_busy_cycles", 64'(n), 64'd33);
    check("mult_done_pulse", {63'd0, done}, 64'd1);
    wait_idle();

    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(F_DIVU, 32'd100, 32'd7);
    issue(F_DIVU, 32'h64, 32'd0);
    check("divu_zero_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("intmin_div", {hi, lo}, {32'd0, 32'h8000_0000});

    // Requests while busy are stalled and leave HI/LO alone
    launch(F_MULT, 32'd1234, 32'hFFFF_0001);
    repeat (4) @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; funct = F_MFLO;
    #1 check("stall_mflo", {63'd0, stall}, 64'd1);
    @(negedge clk);
    funct = F_MTHI; RA = 32'hDEAD_BEEF;
    #1 check("stall_mthi", {63'd0, stall}, 64'd1);
    @(negedge clk);
    funct = F_MULTU;
    #1 check("stall_arith", {63'd0, stall}, 64'd1);
    @(negedge clk);
    funct = 6'b100000;
    #1 check("stall_unknown", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; funct = F_MTHI;
    #1 check("stall_nostart", {63'd0, stall}, 64'd0);
    check("hilo_hold_midrun", {hi, lo}, {h0, l0});
    wait_idle();
    move_to(F_MTHI, 32'h1234, 32'h1234, lo);
    move_to(F_MTLO, 32'h5678, 32'h1234, 32'h5678);
    @(negedge clk);
    start = 1'b1; funct = F_MFHI; RA = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    check("mfhi_nochange", {hi, lo}, {32'h1234, 32'h5678});
    check("mfhi_busy", {63'd0, busy}, 64'd0);

    // Async reset mid-DIV aborts without done
    launch(F_DIV, 32'h0000_7777, 32'd5);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(F_MULT, 32'd3, 32'd4);
    check("post_reset_mult", {32'd0, lo}, 64'd12);

    // Randomized ops with biased corner operands
    for (int i = 0; i < 48; i++) begin
      f = ops[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: begin b = 32'd0; a[31] = 1'b0; end
        1: b = $urandom_range(0, 1) ? 32'd1 : 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      issue(f, a, b);
      if ($urandom_range(0, 5) == 0) begin
        a = $urandom;
        if ($urandom_range(0, 1) == 1) move_to(F_MTHI, a, a, lo);
        else                           move_to(F_MTLO, a, hi, a);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end
endmodule
